trade_limiter: RTL
==================

TRADE_LIMITER -- requirements
Module: trade_limiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent trade channels.
REQ-002 Parameter CNT_W, default 8, per-channel trade counter width.
REQ-003 Parameter TOT_W, default 16, aggregate trade counter width.
REQ-004 Parameter DEFAULT_LIMIT, default 99, halt threshold loaded at reset.
REQ-005 Parameter WINDOW, default 1000, window length in slow_clk cycles (used only with TRADE_WINDOW_EN).
REQ-006 slow_clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 enable_count  in  NUM_CH  per-channel count request, one trade per cycle per bit.
REQ-009 limit  in  CNT_W  new halt threshold, applied to all channels.
REQ-010 limit_load  in  1  captures limit into limit_reg on the next edge.
REQ-011 clear_req  in  NUM_CH  per-channel clear/resume request (level, four-phase).
REQ-012 clear_ack  out  NUM_CH  per-channel clear acknowledge.
REQ-013 trade_count  out  NUM_CH*CNT_W  packed per-channel counts, channel 0 in LSBs.
REQ-014 halt_signal  out  NUM_CH  per-channel halt flag.
REQ-015 any_halt  out  1  OR of halt_signal.
REQ-016 total_count  out  TOT_W  saturating count of all accepted trades.
REQ-017 window_tick  out  1  one-cycle pulse at window boundary.

Function
REQ-018 Each channel SHALL run FSM COUNTING/HALTED/CLEARING; all outputs registered.
REQ-019 COUNTING, enable_count=1, count < limit_reg: count increments by 1 next cycle.
REQ-020 COUNTING, enable_count=1, count >= limit_reg: count held, go HALTED, halt_signal=1 next cycle.
REQ-021 HALTED: enable_count ignored, count and halt_signal held.
REQ-022 clear_req=1 in COUNTING or HALTED: go CLEARING, count<=0, halt_signal<=0, clear_ack<=1 next cycle.
REQ-023 CLEARING: clear_ack held 1 and enable_count ignored while clear_req=1; clear_req=0 -> COUNTING, clear_ack<=0.
REQ-024 Simultaneous clear_req and enable_count: clear wins, trade not counted.
REQ-025 limit_load=1: limit_reg<=limit; channels compare against new value from the following cycle; limit 0 halts on first enable.
REQ-026 total_count SHALL add popcount of trades accepted per REQ-019 that cycle, saturate at 2^TOT_W-1, clear only on reset.
REQ-027 any_halt SHALL be combinational OR of registered halt_signal.

Reset
REQ-028 reset=1 forces, without clock: all channels COUNTING, trade_count=0, halt_signal=0, clear_ack=0, total_count=0, limit_reg=DEFAULT_LIMIT, window counter=0, window_tick=0.
REQ-029 Reset mid-handshake SHALL abort it; channel resumes in COUNTING after release.

Configuration
REQ-030 Macro TRADE_WINDOW_EN defined: window counter counts 0..WINDOW-1, wraps; at wrap window_tick=1 for one cycle and every COUNTING channel's count<=0 (HALTED/CLEARING untouched); wrap coinciding with enable: count<=0, trade still added to total_count.
REQ-031 TRADE_WINDOW_EN undefined: no window counter, window_tick tied 0, counts persist until clear/reset.

Structure
REQ-032 Package trade_pkg SHALL hold channel state enum and DEFAULT_LIMIT/WINDOW default constants.
REQ-033 Sub-module trade_channel (one FSM + counter + ack) SHALL be instantiated NUM_CH times; top holds limit_reg, window counter, total_count.

Verification
REQ-034 Ch0 enable held, limit 99: count 0..99 in 99 cycles, halt_signal[0]=1 on 100th enable, count stays 99.
REQ-035 Ch1 halted, clear_req 1 for 3 cycles: count=0, halt=0, clear_ack high 3 cycles, drops cycle after clear_req falls.
REQ-036 Count 50, load limit 10: next enable halts at 50; total_count unchanged by that enable.
REQ-037 All 4 enables for 5 cycles with TOT_W=4: total_count saturates at 15.
REQ-038 TRADE_WINDOW_EN, WINDOW=8: continuous enable on ch2 -> count 0..7 then 0, window_tick every 8 cycles; halted ch3 keeps count.
REQ-039 reset asserted during CLEARING: immediate zero outputs, ch counts normally after release.

Source files
------------

// File: rtl/trade_pkg.sv
// Shared types and default constants for the trade limiter slice.
// TRADE_WINDOW_EN (optional) enables the periodic count-reset window in the top.
package trade_pkg;

  // Per-channel FSM state; also exported on the debug state bus.
  typedef enum logic [1:0] {
    ST_COUNTING = 2'd0,
    ST_HALTED   = 2'd1,
    ST_CLEARING = 2'd2
  } ch_state_t;

  localparam int DEFAULT_LIMIT_C = 99;
  localparam int WINDOW_C        = 1000;

endpackage

// File: rtl/trade_limiter_if.sv
// Bus interface for the trade limiter: count requests, limit load,
// per-channel clear handshake, and registered status outputs.
//
// Clear handshake (four-phase, level based, per channel): the requester
// raises clear_req and holds it; the channel answers with clear_ack one
// cycle later and holds it while clear_req stays high; after clear_req
// falls, clear_ack falls on the next edge and the channel resumes counting.
// enable_count is a fire-and-forget request: one trade per cycle per bit.
interface trade_limiter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int TOT_W  = 16
);
  logic [NUM_CH-1:0]       enable_count;
  logic [CNT_W-1:0]        limit;
  logic                    limit_load;
  logic [NUM_CH-1:0]       clear_req;
  logic [NUM_CH-1:0]       clear_ack;
  logic [NUM_CH*CNT_W-1:0] trade_count;
  logic [NUM_CH-1:0]       halt_signal;
  logic                    any_halt;
  logic [TOT_W-1:0]        total_count;
  logic                    window_tick;
  logic [2*NUM_CH-1:0]     dbg_state;

  modport master (
    output enable_count, limit, limit_load, clear_req,
    input  clear_ack, trade_count, halt_signal, any_halt, total_count,
           window_tick, dbg_state
  );

  modport slave (
    input  enable_count, limit, limit_load, clear_req,
    output clear_ack, trade_count, halt_signal, any_halt, total_count,
           window_tick, dbg_state
  );
endinterface

// File: rtl/trade_channel.sv
// One trade channel: COUNTING/HALTED/CLEARING FSM with registered count,
// halt flag and clear acknowledge. o_accept flags a trade counted this cycle.
module trade_channel
  import trade_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clear_req,
  input  logic             i_wrap,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_halt,
  output logic             o_ack,
  output logic             o_accept,
  output ch_state_t        o_state
);

  ch_state_t        r_state;
  ch_state_t        w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next_count;
  logic             r_halt;
  logic             w_next_halt;
  logic             r_ack;
  logic             w_next_ack;
  logic             w_accept;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_COUNTING;
    else       r_state <= w_next_state;
  end

  // Next-state decode; clear has priority over counting.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COUNTING: begin
        if (i_clear_req)                               w_next_state = ST_CLEARING;
        else if (i_en && !i_wrap && r_count >= i_limit) w_next_state = ST_HALTED;
      end
      ST_HALTED:   if (i_clear_req)  w_next_state = ST_CLEARING;
      ST_CLEARING: if (!i_clear_req) w_next_state = ST_COUNTING;
      default:     w_next_state = ST_COUNTING;
    endcase
  end

  // Next values for the registered outputs and the accepted-trade flag.
  always_comb begin
    w_next_count = r_count;
    w_next_halt  = r_halt;
    w_next_ack   = r_ack;
    w_accept     = 1'b0;
    case (r_state)
      ST_COUNTING: begin
        if (i_clear_req) begin
          w_next_count = '0;
          w_next_halt  = 1'b0;
          w_next_ack   = 1'b1;
        end else begin
          w_accept = i_en && (r_count < i_limit);
          // A window wrap zeroes the count even when a trade lands that cycle.
          if (i_wrap)        w_next_count = '0;
          else if (w_accept) w_next_count = r_count + 1'b1;
          else if (i_en)     w_next_halt  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (i_clear_req) begin
          w_next_count = '0;
          w_next_halt  = 1'b0;
          w_next_ack   = 1'b1;
        end
      end
      ST_CLEARING: begin
        if (!i_clear_req) w_next_ack = 1'b0;
      end
      default: begin
        w_next_count = '0;
        w_next_halt  = 1'b0;
        w_next_ack   = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_halt  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_halt  <= w_next_halt;
      r_ack   <= w_next_ack;
    end
  end

  assign o_count  = r_count;
  assign o_halt   = r_halt;
  assign o_ack    = r_ack;
  assign o_accept = w_accept;
  assign o_state  = r_state;

endmodule

// File: rtl/trade_limiter.sv
// Trade limiter top: shared halt threshold, NUM_CH trade channels and a
// saturating aggregate counter. Defining TRADE_WINDOW_EN adds a window
// counter that periodically zeroes counting channels and pulses window_tick.
module trade_limiter
  import trade_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 8,
  parameter int TOT_W         = 16,
  parameter int DEFAULT_LIMIT = DEFAULT_LIMIT_C,
  parameter int WINDOW        = WINDOW_C
) (
  input  logic            slow_clk,
  input  logic            reset,
  trade_limiter_if.slave  bus
);

  localparam int               SUM_W     = TOT_W + $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] LIMIT_RST = CNT_W'(DEFAULT_LIMIT);
  localparam logic [SUM_W-1:0] TOT_MAX   = {{(SUM_W-TOT_W){1'b0}}, {TOT_W{1'b1}}};

  logic [CNT_W-1:0]  r_limit;
  logic [TOT_W-1:0]  r_total;
  logic [SUM_W-1:0]  w_sum;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_halt;
  logic              w_wrap;

  // Threshold register; channels see a new value from the following cycle.
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset)               r_limit <= LIMIT_RST;
    else if (bus.limit_load) r_limit <= bus.limit;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t w_state;
    trade_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk       (slow_clk),
      .i_rst       (reset),
      .i_en        (bus.enable_count[g]),
      .i_clear_req (bus.clear_req[g]),
      .i_wrap      (w_wrap),
      .i_limit     (r_limit),
      .o_count     (bus.trade_count[g*CNT_W +: CNT_W]),
      .o_halt      (w_halt[g]),
      .o_ack       (bus.clear_ack[g]),
      .o_accept    (w_accept[g]),
      .o_state     (w_state)
    );
    assign bus.dbg_state[2*g +: 2] = w_state;
  end

  // Running total plus this cycle's accepted trades, clipped at all-ones.
  always_comb begin
    w_sum = {{(SUM_W-TOT_W){1'b0}}, r_total};
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum + SUM_W'(w_accept[i]);
    end
    if (w_sum > TOT_MAX) w_sum = TOT_MAX;
  end

  // Aggregate counter register; only reset clears it.
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) r_total <= '0;
    else       r_total <= w_sum[TOT_W-1:0];
  end

`ifdef TRADE_WINDOW_EN
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [WIN_W-1:0] r_win_cnt;
  logic             r_tick;

  assign w_wrap = (r_win_cnt == WIN_W'(WINDOW - 1));

  // Window counter 0..WINDOW-1 with a registered tick at each wrap.
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      r_win_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_win_cnt <= w_wrap ? '0 : r_win_cnt + 1'b1;
      r_tick    <= w_wrap;
    end
  end

  assign bus.window_tick = r_tick;
`else
  assign w_wrap          = 1'b0;
  assign bus.window_tick = 1'b0;
`endif

  assign bus.halt_signal = w_halt;
  assign bus.any_halt    = |w_halt;
  assign bus.total_count = r_total;

endmodule
